// File: rtl/spart_pkg.sv
// Shared SPART constants: register addresses and default generator sizing.
package spart_pkg;
  localparam logic [1:0] SPART_ADDR_DB_LO = 2'b10;
  localparam logic [1:0] SPART_ADDR_DB_HI = 2'b11;
  localparam int SPART_DIV_W_DEFAULT      = 16;
  localparam int SPART_OVERSAMPLE_DEFAULT = 16;
endpackage

// File: rtl/spart_baud_gen_if.sv
// Processor-bus side of the baud generator plus its two tick outputs.
interface spart_baud_gen_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus_in;
  logic [7:0] databus_out;
  logic       rx_tick;
  logic       tx_tick;

  modport master (
    output iocs, iorw, ioaddr, databus_in,
    input  databus_out, rx_tick, tx_tick
  );

  modport slave (
    input  iocs, iorw, ioaddr, databus_in,
    output databus_out, rx_tick, tx_tick
  );
endinterface

// File: rtl/spart_baud_gen_reload_counter.sv
// Loadable down-counter; term is high while the count is zero, and an enabled
// count at zero reloads load_val instead of wrapping. load has priority over en.
module reload_counter #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         term
);
  logic [W-1:0] cnt;

  assign term = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= RST_VAL;
    else if (load)
      cnt <= load_val;
    else if (en)
      cnt <= term ? load_val : cnt - W'(1);
  end
endmodule

// File: rtl/spart_baud_gen.sv
// SPART baud generator: staged divisor, registered rx_tick every D+1 cycles, tx_tick every OVERSAMPLE rx_ticks.
// Define SPART_BAUD_READBACK_EN to make the divisor readable on databus_out.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter int DIV_W       = SPART_DIV_W_DEFAULT,
  parameter int OVERSAMPLE  = SPART_OVERSAMPLE_DEFAULT,
  parameter int DEFAULT_DIV = 162
) (
  input logic             clk,
  input logic             rst,
  spart_baud_gen_if.slave bus
);
  localparam int             OS_W   = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MAX = OS_W'(OVERSAMPLE - 1);

  logic [7:0]       lo_hold;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] new_div;
  logic [DIV_W-1:0] div_load;
  logic             wr;
  logic             wr_lo;
  logic             commit;
  logic             running;
  logic             div_term;
  logic             os_term;
  logic             tick;
  logic             rx_tick_q;
  logic             tx_tick_q;

  assign wr      = bus.iocs && !bus.iorw;
  assign wr_lo   = wr && (bus.ioaddr == SPART_ADDR_DB_LO);
  assign commit  = wr && (bus.ioaddr == SPART_ADDR_DB_HI);
  assign new_div = {bus.databus_in[DIV_W-9:0], lo_hold};
  assign running = (div_act != '0);
  // A commit landing on the terminal count swallows that tick and restarts the phase.
  assign tick     = running && !commit && div_term;
  assign div_load = commit ? new_div : div_act;

  reload_counter #(
    .W       (DIV_W),
    .RST_VAL (DIV_W'(DEFAULT_DIV))
  ) u_div_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (running),
    .load     (commit),
    .load_val (div_load),
    .term     (div_term)
  );

  // Counts down from OVERSAMPLE-1, so term marks the last rx_tick of a bit.
  reload_counter #(
    .W       (OS_W),
    .RST_VAL (OS_MAX)
  ) u_os_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (tick),
    .load     (commit),
    .load_val (OS_MAX),
    .term     (os_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_hold   <= '0;
      div_act   <= DIV_W'(DEFAULT_DIV);
      rx_tick_q <= 1'b0;
      tx_tick_q <= 1'b0;
    end else begin
      if (wr_lo)
        lo_hold <= bus.databus_in;
      if (commit)
        div_act <= new_div;
      rx_tick_q <= tick;
      tx_tick_q <= tick && os_term;
    end
  end

  assign bus.rx_tick = rx_tick_q;
  assign bus.tx_tick = tx_tick_q;

`ifdef SPART_BAUD_READBACK_EN
  logic [15:0] div_ext;
  logic [7:0]  rd_dat;

  assign div_ext = 16'(div_act);

  always_comb begin
    rd_dat = 8'h00;
    if (bus.iocs && bus.iorw) begin
      case (bus.ioaddr)
        SPART_ADDR_DB_LO: rd_dat = div_ext[7:0];
        SPART_ADDR_DB_HI: rd_dat = div_ext[15:8];
        default:          rd_dat = 8'h00;
      endcase
    end
  end

  assign bus.databus_out = rd_dat;
`else
  assign bus.databus_out = 8'h00;
`endif
endmodule

// File: doc/spart_baud_gen.md
# spart_baud_gen

Parametrised baud-rate generator for the SPART. It holds a programmable divisor written over the 8-bit processor bus, and produces a registered oversample enable (`rx_tick`) for the receiver and a derived bit enable (`tx_tick`) for the transmitter. Divisor updates are staged and committed atomically, so the counter never runs on a half-written divisor. It sits beside the SPART TX/RX blocks and decodes only divisor addresses.

## Interface
Parameters:
- `DIV_W`, default 16: divisor width; legal range 9..16.
- `OVERSAMPLE`, default 16: number of `rx_tick`s per `tx_tick`; must be a power of 2, minimum 2.
- `DEFAULT_DIV`, default 162: divisor loaded at reset; must fit in `DIV_W`.

Ports (clock and reset first):
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `iocs`  in  1  chip select
- `iorw`  in  1  1 = read, 0 = write
- `ioaddr`  in  2  register address; 2'b10 = DB_LO, 2'b11 = DB_HI; 00 and 01 are ignored
- `databus_in`  in  8  write data
- `databus_out`  out  8  read data (see Configuration)
- `rx_tick`  out  1  one-cycle oversample enable
- `tx_tick`  out  1  one-cycle bit enable; only ever high together with `rx_tick`

## Operation
- Registers:
  - `lo_hold` (8 bits)
  - `div_act` (`DIV_W` bits)
  - `cnt` (`DIV_W` bits)
  - `os_cnt` (log2(`OVERSAMPLE`) bits)
  - `rx_tick` and `tx_tick` flops
- Write to DB_LO (`iocs && !iorw && ioaddr==2'b10`): `lo_hold <= databus_in`. `div_act` is unchanged.
- Write to DB_HI is a commit:
  - `div_act <= {databus_in[DIV_W-9:0], lo_hold}`; high bits beyond `DIV_W` are dropped.
  - `cnt <= new divisor` and `os_cnt <= 0`.
  - `rx_tick` and `tx_tick` are forced to 0 on that edge.
- Running (`div_act != 0`, no commit):
  - `cnt != 0`: `cnt` decrements.
  - `cnt == 0`: `cnt <= div_act` and the `rx_tick` flop is set to 1.
  - `os_cnt` increments on each generated tick and wraps at `OVERSAMPLE-1`.
  - The `tx_tick` flop is set when a tick is generated while `os_cnt == OVERSAMPLE-1`.
- Disabled (`div_act == 0`): `cnt` is held at 0 and both ticks stay at 0. There is no free-running every-cycle tick.
- Arithmetic is unsigned. `cnt` never underflows.

## Timing
- Reset values: `lo_hold = 0`, `div_act = DEFAULT_DIV`, `cnt = DEFAULT_DIV`, `os_cnt = 0`, `rx_tick = 0`, `tx_tick = 0`, `databus_out = 0`.
- Divisor D committed at edge E0:
  - First `rx_tick` is high in the cycle D+1 cycles after E0.
  - `rx_tick` period is D+1 cycles.
  - First `tx_tick` occurs OVERSAMPLE·(D+1) cycles after E0; period OVERSAMPLE·(D+1).
- After reset release, behaviour is identical, with reset deassertion taking the place of E0.
- Commit in the same cycle as `cnt == 0`: the commit wins; no tick; `cnt` reloads the new divisor.
- DB_LO write in the same cycle as a terminal count: the tick proceeds normally.
- Back-to-back DB_HI writes: each one restarts the phase.
- Reset asserted mid-count: all state clears immediately (asynchronously), including any in-flight tick.
- Reads and accesses to ioaddr 00/01 never disturb the counters.

## Configuration
- `SPART_BAUD_READBACK_EN` defined:
  - `databus_out` is combinational, and non-zero only when `iocs && iorw`.
  - ioaddr 2'b10 returns `div_act[7:0]`.
  - ioaddr 2'b11 returns `div_act[DIV_W-1:8]`, zero-extended.
  - All other addresses return 0.
- Macro undefined: `databus_out` is tied to 8'h00 and no read decode logic is built.

## Structure
- Shared package `spart_pkg` holds:
  - address constants `SPART_ADDR_DB_LO = 2'b10` and `SPART_ADDR_DB_HI = 2'b11`;
  - `SPART_DIV_W_DEFAULT = 16`;
  - `SPART_OVERSAMPLE_DEFAULT = 16`.
- One sub-module, `reload_counter`:
  - parameter `W`; inputs `en`, `load`, `load_val`; output `term`;
  - a loadable counter with a terminal-count output.
  - Instantiated twice: once as the divisor down-counter, once as the oversample counter.

## Test plan
- Reset with `DEFAULT_DIV = 162` → first `rx_tick` 163 cycles after reset release; `tx_tick` at 2608 cycles.
- Write DB_LO = 8'h03, then DB_HI = 8'h00 → `rx_tick` every 4 cycles, first one 4 cycles after the commit; `tx_tick` every 64 cycles, coinciding with `rx_tick`.
- DB_LO = 8'h09 written alone → period is unchanged. Then DB_HI = 8'h00 → period becomes 10 cycles.
- Commit D = 0 (DB_LO = 0, DB_HI = 0) → no ticks for 1000 cycles. Then commit D = 1 → ticks every 2 cycles.
- Commit timed to the exact cycle where `cnt == 0` → no tick that cycle; next tick D+1 cycles later. Also assert `rst` mid-count → ticks cease immediately and restart with `DEFAULT_DIV` phasing.
- With `SPART_BAUD_READBACK_EN`: commit 16'h1234, read ioaddr 10 → 8'h34, read ioaddr 11 → 8'h12. Without the macro → both reads return 8'h00.
